mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port basicMemory (sync read, 1-cycle dout latency) between two requesters:
//  port C = multicycle core (IorD mux output), port L = debug/program loader.
//  Sits between the requesters and the memory. Accepts one command at a time, sequences the
//  memory cycle and returns read data. Round-robin arbitration; L may lock for burst loads,
//  bounded by a starvation limit.
// PARAMETERS
//  ADDR_W    8   memory word address width (matches basicMemory ad)
//  DATA_W    32  data width
//  LOCK_MAX  16  max consecutive locked L grants before one pending C request is forced through
// PORTS
//  clk       in   1       system clock, all state on posedge
//  rst       in   1       synchronous, active-high reset
//  c_req     in   1       core request; hold req/we/addr/wdata stable until c_ack
//  c_we      in   1       1 = write, 0 = read
//  c_addr    in   ADDR_W  core address
//  c_wdata   in   DATA_W  core write data
//  c_ack     out  1       command accepted (combinational, IDLE only)
//  c_rvalid  out  1       1-cycle pulse: core transaction complete (reads: c_rdata valid)
//  c_rdata   out  DATA_W  core read data, held until next core read completes
//  l_req, l_we, l_addr, l_wdata, l_ack, l_rvalid, l_rdata   loader equivalents of the above
//  l_lock    in   1       loader requests exclusive ownership across consecutive transactions
//  mem_ce    out  1       memory chip enable (ISSUE state only)
//  mem_wre   out  1       memory write enable (ISSUE state only, = latched we)
//  mem_ad    out  ADDR_W  latched address
//  mem_din   out  DATA_W  latched write data
//  mem_dout  in   DATA_W  memory read data, valid the cycle after mem_ce
//  busy      out  1       state != IDLE
//  owner     out  1       0 = C, 1 = L; owner of current/last transaction
// BEHAVIOUR
//  - States: IDLE -> ISSUE -> CAPTURE -> IDLE. Fixed 3 cycles per transaction, no back-to-back.
//  - IDLE: winner picked combinationally; winner's *_ack = 1 in cycle T; at T's edge latch
//    we/addr/wdata/owner, go ISSUE. Loser sees ack = 0, keeps req high.
//  - ISSUE (T+1): mem_ce = 1, mem_wre = latched we. Go CAPTURE.
//  - CAPTURE (T+2): for reads, owner's rdata reg <= mem_dout at edge. Go IDLE.
//  - T+3 (IDLE): owner's *_rvalid = 1 for exactly one cycle (reads and writes). A new command
//    may be accepted in the same cycle.
//  - Arbitration: only C or only L requesting -> that port wins. Both -> winner != last owner
//    (round-robin), unless lock active.
//  - Lock active = last owner L, that transaction accepted with l_lock = 1, and l_lock still 1.
//    While active, L wins ties; if L idle, C may still be served (clears lock).
//  - lock_cnt counts consecutive locked L grants while c_req pending. At LOCK_MAX, next tie
//    goes to C; lock_cnt <= 0. lock_cnt also clears on any C grant.
//  - Outputs outside their state are 0 (mem_ce, mem_wre, acks, rvalids); mem_ad/mem_din
//    show latched values.
//  - Reset (any state, incl. mid-transaction): state = IDLE; all acks/rvalids/mem_ce/mem_wre = 0;
//    rdata regs = 0; latched addr/data/we = 0; owner/last owner = 1 (C wins first tie);
//    lock_cnt = 0. In-flight transaction dropped; no rvalid issued for it.
//  - req dropped before ack: nothing happens. req dropped after ack: transaction still completes.
// TESTING
//  1. Reset, C read addr 0x05 (mem[5]=0xDEADBEEF): c_ack @T, mem_ce @T+1, c_rvalid @T+3,
//     c_rdata = 0xDEADBEEF; L outputs stay 0.
//  2. C & L both req from reset: C acked first, L acked @T+3 (same cycle as c_rvalid);
//     alternation C,L,C,L over 4 transactions.
//  3. L write 0x10 <= 0x12345678 then C read 0x10: mem_wre=1 only @ISSUE, C reads 0x12345678.
//  4. L lock=1 with 20 writes, C req held throughout, LOCK_MAX=16: C acked right after 16th
//     locked L grant; L resumes; lock_cnt back to 0.
//  5. rst asserted in ISSUE of an L read: next cycle IDLE, no l_rvalid, l_rdata=0, mem_ce=0;
//     pending C then served normally.
//  6. Write to 0xFF then read 0xFF (top address, no wrap): data returns intact, addr 0x00
//     unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the two requester ports (core C, loader L), the basicMemory-side
//   signals and the status outputs of mem_port_arbiter.
//   slave  : the arbiter's view (requests and mem_dout in, acks/data/memory controls out)
//   master : the environment's view (requesters plus memory), directions reversed
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              c_req;
   logic              c_we;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata;
   logic              c_ack;
   logic              c_rvalid;
   logic [DATA_W-1:0] c_rdata;

   logic              l_req;
   logic              l_we;
   logic [ADDR_W-1:0] l_addr;
   logic [DATA_W-1:0] l_wdata;
   logic              l_lock;
   logic              l_ack;
   logic              l_rvalid;
   logic [DATA_W-1:0] l_rdata;

   logic              mem_ce;
   logic              mem_wre;
   logic [ADDR_W-1:0] mem_ad;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;

   logic              busy;
   logic              owner;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      input  l_req, l_we, l_addr, l_wdata, l_lock,
      input  mem_dout,
      output c_ack, c_rvalid, c_rdata,
      output l_ack, l_rvalid, l_rdata,
      output mem_ce, mem_wre, mem_ad, mem_din,
      output busy, owner
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata,
      output l_req, l_we, l_addr, l_wdata, l_lock,
      output mem_dout,
      input  c_ack, c_rvalid, c_rdata,
      input  l_ack, l_rvalid, l_rdata,
      input  mem_ce, mem_wre, mem_ad, mem_din,
      input  busy, owner
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single-port synchronous-read memory between the multicycle core
//   (port C) and the debug/program loader (port L). One command at a time,
//   fixed IDLE -> ISSUE -> CAPTURE -> IDLE sequence. Round-robin between the
//   ports; the loader may lock the memory for bursts, bounded by LOCK_MAX
//   consecutive locked grants while the core is waiting.
// Ports
//   clk, rst : clock and synchronous active-high reset
//   bus      : mem_port_arbiter_if.slave
//              c_*/l_* requester handshakes (ack combinational in IDLE,
//              rvalid one-cycle pulse, rdata held), l_lock burst request,
//              mem_ce/mem_wre/mem_ad/mem_din/mem_dout memory side,
//              busy (not IDLE), owner (0 = C, 1 = L, current/last transaction)
module mem_port_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 16
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t            state_r;
   state_t            next_state_s;
   logic              we_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic              owner_r;
   logic              lock_r;
   logic [CNT_W-1:0]  lock_cnt_r;
   logic              c_rvalid_r;
   logic              l_rvalid_r;
   logic [DATA_W-1:0] c_rdata_r;
   logic [DATA_W-1:0] l_rdata_r;
   logic              lock_active_s;
   logic              grant_c_s;
   logic              grant_l_s;

   // Lock holds only while L owned the last transaction, accepted it locked,
   // and still asserts l_lock now.
   assign lock_active_s = owner_r & lock_r & bus.l_lock;

   // Next-state and grant decision.
   always_comb begin
      next_state_s = state_r;
      grant_c_s    = 1'b0;
      grant_l_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.c_req && bus.l_req) begin
               if (lock_active_s) begin
                  // Starvation guard: after LOCK_MAX locked grants the core gets one turn.
                  if (lock_cnt_r == CNT_W'(LOCK_MAX)) begin
                     grant_c_s = 1'b1;
                  end else begin
                     grant_l_s = 1'b1;
                  end
               end else if (owner_r) begin
                  grant_c_s = 1'b1;
               end else begin
                  grant_l_s = 1'b1;
               end
            end else if (bus.c_req) begin
               grant_c_s = 1'b1;
            end else if (bus.l_req) begin
               grant_l_s = 1'b1;
            end else begin
               grant_c_s = 1'b0;
               grant_l_s = 1'b0;
            end
            if (grant_c_s || grant_l_s) begin
               next_state_s = ISSUE;
            end else begin
               next_state_s = IDLE;
            end
         end
         ISSUE:   next_state_s = CAPTURE;
         CAPTURE: next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Command latch, ownership and lock bookkeeping at acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_r       <= 1'b0;
         addr_r     <= '0;
         wdata_r    <= '0;
         owner_r    <= 1'b1;
         lock_r     <= 1'b0;
         lock_cnt_r <= '0;
      end else if (grant_c_s) begin
         we_r       <= bus.c_we;
         addr_r     <= bus.c_addr;
         wdata_r    <= bus.c_wdata;
         owner_r    <= 1'b0;
         lock_r     <= 1'b0;
         lock_cnt_r <= '0;
      end else if (grant_l_s) begin
         we_r    <= bus.l_we;
         addr_r  <= bus.l_addr;
         wdata_r <= bus.l_wdata;
         owner_r <= 1'b1;
         lock_r  <= bus.l_lock;
         // Only locked grants taken while the core waits count toward the limit;
         // the count cannot pass LOCK_MAX because the core wins that tie.
         if (!bus.l_lock) begin
            lock_cnt_r <= '0;
         end else if (bus.c_req) begin
            lock_cnt_r <= lock_cnt_r + CNT_W'(1);
         end
      end
   end

   // Completion pulse and read-data capture at the end of CAPTURE.
   always_ff @(posedge clk) begin
      if (rst) begin
         c_rvalid_r <= 1'b0;
         l_rvalid_r <= 1'b0;
         c_rdata_r  <= '0;
         l_rdata_r  <= '0;
      end else begin
         c_rvalid_r <= (state_r == CAPTURE) && !owner_r;
         l_rvalid_r <= (state_r == CAPTURE) && owner_r;
         if ((state_r == CAPTURE) && !we_r) begin
            if (owner_r) begin
               l_rdata_r <= bus.mem_dout;
            end else begin
               c_rdata_r <= bus.mem_dout;
            end
         end
      end
   end

   assign bus.c_ack    = grant_c_s;
   assign bus.l_ack    = grant_l_s;
   assign bus.c_rvalid = c_rvalid_r;
   assign bus.l_rvalid = l_rvalid_r;
   assign bus.c_rdata  = c_rdata_r;
   assign bus.l_rdata  = l_rdata_r;
   assign bus.mem_ce   = (state_r == ISSUE);
   assign bus.mem_wre  = (state_r == ISSUE) && we_r;
   assign bus.mem_ad   = addr_r;
   assign bus.mem_din  = wdata_r;
   assign bus.busy     = (state_r != IDLE);
   assign bus.owner    = owner_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Drives both requester ports, models the synchronous-read memory and
//   checks the arbiter with a vector table plus hand-written sequences for
//   round-robin, lock starvation and mid-transaction reset. Completions are
//   matched against a scoreboard filled at command acceptance.
module tb_mem_port_arbiter;
   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .LOCK_MAX(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Memory model: synchronous read, one-cycle dout latency.
   logic [31:0] mem [256];
   always @(posedge clk) begin
      if (bus.mem_ce) begin
         if (bus.mem_wre) mem[bus.mem_ad] <= bus.mem_din;
         bus.mem_dout <= mem[bus.mem_ad];
      end
   end

   // Bench-side expected memory contents, updated when a write is accepted.
   logic [31:0] shadow [256];

   typedef struct {
      bit          port;
      bit          rd;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      bit          port;
      bit          we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs [7];

   bit glog[$];
   int gcyc[$];
   bit rvlog[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic sb_push(input bit port, input logic we, input logic [7:0] a, input logic [31:0] d);
      exp_t e;
      e.port = port;
      e.rd   = !we;
      e.data = shadow[a];
      if (we) shadow[a] = d;
      sb.push_back(e);
   endtask

   task automatic sb_pop(input bit port, input logic [31:0] rdata);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_rvalid: got rvalid on port %0d expected none", port);
      end else begin
         e = sb.pop_front();
         check("sb_port", {31'd0, port}, {31'd0, e.port});
         if (e.rd) check("sb_rdata", rdata, e.data);
      end
   endtask

   // Completion monitor, sampling on the inactive edge.
   always @(negedge clk) begin
      if (bus.c_rvalid) sb_pop(1'b0, bus.c_rdata);
      if (bus.l_rvalid) sb_pop(1'b1, bus.l_rdata);
   end

   task automatic do_reset();
      rst = 1'b1;
      bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = 8'h00; bus.c_wdata = 32'h0;
      bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = 8'h00; bus.l_wdata = 32'h0;
      bus.l_lock = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      #1;
      while (sb.size() != 0 && t < 10) begin
         @(negedge clk); #1;
         t++;
      end
      check("sb_drain", sb.size(), 32'd0);
   endtask

   // One isolated transaction with cycle-exact checks of ack/mem_ce/rvalid.
   task automatic run_single(input vec_t v, input int idx);
      int   t = 0;
      logic ack;
      @(negedge clk);
      if (v.port) begin
         bus.l_we = v.we; bus.l_addr = v.addr; bus.l_wdata = v.wdata; bus.l_req = 1'b1;
      end else begin
         bus.c_we = v.we; bus.c_addr = v.addr; bus.c_wdata = v.wdata; bus.c_req = 1'b1;
      end
      #1;
      ack = v.port ? bus.l_ack : bus.c_ack;
      while (!ack && t < 8) begin
         @(negedge clk); #1;
         ack = v.port ? bus.l_ack : bus.c_ack;
         t++;
      end
      check($sformatf("v%0d_ack", idx), {31'd0, ack}, 32'd1);
      check($sformatf("v%0d_other_ack", idx), {31'd0, v.port ? bus.c_ack : bus.l_ack}, 32'd0);
      if (ack) sb_push(v.port, v.we, v.addr, v.wdata);
      @(negedge clk);
      bus.c_req = 1'b0; bus.l_req = 1'b0;
      #1;
      check($sformatf("v%0d_issue_ce", idx), {31'd0, bus.mem_ce}, 32'd1);
      check($sformatf("v%0d_issue_wre", idx), {31'd0, bus.mem_wre}, {31'd0, v.we});
      check($sformatf("v%0d_issue_ad", idx), {24'd0, bus.mem_ad}, {24'd0, v.addr});
      if (v.we) check($sformatf("v%0d_issue_din", idx), bus.mem_din, v.wdata);
      @(negedge clk); #1;
      check($sformatf("v%0d_capture_ce", idx), {31'd0, bus.mem_ce}, 32'd0);
      check($sformatf("v%0d_capture_wre", idx), {31'd0, bus.mem_wre}, 32'd0);
      @(negedge clk); #1;
      check($sformatf("v%0d_rvalid", idx), {31'd0, v.port ? bus.l_rvalid : bus.c_rvalid}, 32'd1);
      check($sformatf("v%0d_other_rvalid", idx), {31'd0, v.port ? bus.c_rvalid : bus.l_rvalid}, 32'd0);
      if (!v.we) check($sformatf("v%0d_rdata", idx), v.port ? bus.l_rdata : bus.c_rdata, v.exp);
   endtask

   // Observe acks with requests held; logs winner, cycle and rvalid at each grant.
   // The loader's address/data advance after each of its grants.
   task automatic watch(input int ngrants, input int budget);
      int cyc = 0;
      bit adv_l = 1'b0;
      glog.delete(); gcyc.delete(); rvlog.delete();
      while (glog.size() < ngrants && cyc < budget) begin
         #1;
         cyc++;
         if (bus.c_ack && bus.l_ack) check("double_ack", 32'd1, 32'd0);
         if (bus.c_ack) begin
            sb_push(1'b0, bus.c_we, bus.c_addr, bus.c_wdata);
            glog.push_back(1'b0); gcyc.push_back(cyc);
            rvlog.push_back(bus.c_rvalid | bus.l_rvalid);
         end else if (bus.l_ack) begin
            sb_push(1'b1, bus.l_we, bus.l_addr, bus.l_wdata);
            glog.push_back(1'b1); gcyc.push_back(cyc);
            rvlog.push_back(bus.c_rvalid | bus.l_rvalid);
            adv_l = 1'b1;
         end
         @(negedge clk);
         if (adv_l) begin
            bus.l_addr  = bus.l_addr + 8'd1;
            bus.l_wdata = bus.l_wdata + 32'd1;
            adv_l = 1'b0;
         end
      end
      check("watch_grants", glog.size(), ngrants);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit exp_seq [22];
      clk = 1'b0;
      for (int i = 0; i < 256; i++) begin
         mem[i]    = 32'hA000_0000 | i;
         shadow[i] = 32'hA000_0000 | i;
      end
      mem[5] = 32'hDEAD_BEEF; shadow[5] = 32'hDEAD_BEEF;
      mem[0] = 32'h0BAD_F00D; shadow[0] = 32'h0BAD_F00D;
      bus.mem_dout = 32'h0;

      vecs[0] = '{1'b0, 1'b0, 8'h05, 32'h0,         32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 1'b1, 8'h10, 32'h1234_5678, 32'h0};
      vecs[2] = '{1'b0, 1'b0, 8'h10, 32'h0,         32'h1234_5678};
      vecs[3] = '{1'b0, 1'b1, 8'hFF, 32'hCAFE_0FF0, 32'h0};
      vecs[4] = '{1'b1, 1'b0, 8'hFF, 32'h0,         32'hCAFE_0FF0};
      vecs[5] = '{1'b0, 1'b0, 8'h00, 32'h0,         32'h0BAD_F00D};
      vecs[6] = '{1'b1, 1'b0, 8'h05, 32'h0,         32'hDEAD_BEEF};

      // Reset state
      do_reset();
      #1;
      check("rst_busy",   {31'd0, bus.busy},    32'd0);
      check("rst_owner",  {31'd0, bus.owner},   32'd1);
      check("rst_mem_ce", {31'd0, bus.mem_ce},  32'd0);
      check("rst_mem_wre",{31'd0, bus.mem_wre}, 32'd0);
      check("rst_mem_ad", {24'd0, bus.mem_ad},  32'd0);
      check("rst_mem_din", bus.mem_din,         32'd0);
      check("rst_c_rdata", bus.c_rdata,         32'd0);
      check("rst_l_rdata", bus.l_rdata,         32'd0);
      check("rst_rvalids", {30'd0, bus.c_rvalid, bus.l_rvalid}, 32'd0);
      check("rst_acks",    {30'd0, bus.c_ack, bus.l_ack}, 32'd0);

      // Table: single reads/writes, write-then-read, top address, address 0 untouched
      for (int i = 0; i < 7; i++) run_single(vecs[i], i);
      drain();

      // Both ports request from reset: C first, then strict alternation every 3 cycles
      do_reset();
      bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'h05;
      bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 8'h20;
      watch(4, 40);
      bus.c_req = 1'b0; bus.l_req = 1'b0;
      for (int i = 0; i < glog.size(); i++)
         check($sformatf("rr_winner%0d", i), {31'd0, glog[i]}, (i % 2 == 1) ? 32'd1 : 32'd0);
      for (int i = 1; i < gcyc.size(); i++) begin
         check($sformatf("rr_gap%0d", i), gcyc[i] - gcyc[i-1], 32'd3);
         check($sformatf("rr_rvalid_at_ack%0d", i), {31'd0, rvlog[i]}, 32'd1);
      end
      drain();

      // Locked loader burst with core waiting: C, 16 locked L, forced C, L resumes
      do_reset();
      bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'h05;
      bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_lock = 1'b1;
      bus.l_addr = 8'h40; bus.l_wdata = 32'h1000_0000;
      watch(22, 120);
      bus.c_req = 1'b0; bus.l_req = 1'b0; bus.l_lock = 1'b0;
      for (int i = 0; i < 22; i++) exp_seq[i] = !(i == 0 || i == 17);
      for (int i = 0; i < glog.size(); i++)
         check($sformatf("lock_winner%0d", i), {31'd0, glog[i]}, {31'd0, exp_seq[i]});
      drain();

      // Reset during ISSUE of a loader read drops it; pending core read then served
      run_single(vecs[6], 7);
      drain();
      @(negedge clk);
      bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 8'h10;
      #1;
      check("r5_l_ack", {31'd0, bus.l_ack}, 32'd1);
      @(negedge clk);
      bus.l_req = 1'b0;
      rst = 1'b1;
      #1;
      check("r5_in_issue", {31'd0, bus.mem_ce}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'hFF;
      #1;
      check("r5_busy",     {31'd0, bus.busy},     32'd0);
      check("r5_mem_ce",   {31'd0, bus.mem_ce},   32'd0);
      check("r5_l_rvalid", {31'd0, bus.l_rvalid}, 32'd0);
      check("r5_l_rdata",  bus.l_rdata,           32'd0);
      check("r5_owner",    {31'd0, bus.owner},    32'd1);
      watch(1, 10);
      bus.c_req = 1'b0;
      if (glog.size() > 0) check("r5_c_served", {31'd0, glog[0]}, 32'd0);
      repeat (4) @(negedge clk);
      check("r5_c_rdata", bus.c_rdata, 32'hCAFE_0FF0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
